// File: rtl/ads8528_par_ctrl_if.sv
// ADS8528 parallel-bus pins plus the tagged sample stream and status flags.
// master = controller side, slave = ADC/consumer side.
interface ads8528_par_ctrl_if;
   logic        enable;
   logic        busy;
   logic [15:0] db_in;
   logic [15:0] db_out;
   logic        db_oe;
   logic        cs_n;
   logic        wr_n;
   logic        rd_n;
   logic [3:0]  convst;
   logic        hw_n;
   logic        par_n;
   logic        stby_n;
   logic [15:0] s_data;
   logic [2:0]  s_ch;
   logic        s_last;
   logic        s_valid;
   logic        s_ready;
   logic        cfg_done;
   logic        overrun;
   logic        timeout_err;

   modport master (
      input  enable, busy, db_in, s_ready,
      output db_out, db_oe, cs_n, wr_n, rd_n, convst, hw_n, par_n, stby_n,
      output s_data, s_ch, s_last, s_valid, cfg_done, overrun, timeout_err
   );

   modport slave (
      output enable, busy, db_in, s_ready,
      input  db_out, db_oe, cs_n, wr_n, rd_n, convst, hw_n, par_n, stby_n,
      input  s_data, s_ch, s_last, s_valid, cfg_done, overrun, timeout_err
   );
endinterface

// File: rtl/ads8528_par_ctrl.sv
// ADS8528 parallel-mode controller: CONFIG write after reset, then periodic
// CONVST / BUSY / RD_N frames whose results leave on a valid/ready stream.
module ads8528_par_ctrl #(
   parameter int          NUM_CH      = 8,
   parameter int          SAMPLE_DIV  = 1000,
   parameter logic [31:0] CFG_WORD    = 32'h8000_03FF,
   parameter int          WR_LOW_CYC  = 2,
   parameter int          RD_LOW_CYC  = 2,
   parameter int          RD_HIGH_CYC = 2,
   parameter int          CONVST_CYC  = 2,
   parameter int          BUSY_TO     = 255
) (
   input logic                clk,
   input logic                rst,
   ads8528_par_ctrl_if.master bus
);
   localparam int CNT_W = 16;
   localparam int TMR_W = $clog2(SAMPLE_DIV);

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t             WR_LAST   = cnt_t'(WR_LOW_CYC);
   localparam cnt_t             WR_END    = cnt_t'(WR_LOW_CYC + 1);
   localparam cnt_t             CONV_END  = cnt_t'(CONVST_CYC - 1);
   localparam cnt_t             RD_LO_END = cnt_t'(RD_LOW_CYC - 1);
   localparam cnt_t             RD_HI_END = cnt_t'(RD_HIGH_CYC - 1);
   localparam cnt_t             TO_END    = cnt_t'(BUSY_TO - 1);
   localparam logic [2:0]       LAST_CH   = 3'(NUM_CH - 1);
   localparam logic [TMR_W-1:0] TMR_END   = TMR_W'(SAMPLE_DIV - 1);

   typedef enum logic [2:0] {
      CFG_HI, CFG_LO, IDLE, CONV, WAIT_BH, WAIT_BL, RD_LO, RD_HI
   } state_t;

   state_t           state_q, state_d;
   cnt_t             cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic             act_q;
   logic [TMR_W-1:0] tmr_q;
   logic             tick, out_free, in_cfg;
   logic             cap, to_hit, cfg_end;

   logic [15:0]      s_data_q;
   logic [2:0]       s_ch_q;
   logic             s_last_q, s_valid_q;
   logic             cfg_done_q, overrun_q, timeout_q;

   assign tick     = cfg_done_q && (tmr_q == TMR_END);
   // the output register is free if empty or being accepted this edge
   assign out_free = !s_valid_q || bus.s_ready;
   assign in_cfg   = act_q && (state_q == CFG_HI || state_q == CFG_LO);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= CFG_HI;
         cnt_q      <= '0;
         idx_q      <= '0;
         act_q      <= 1'b0;
         tmr_q      <= '0;
         s_data_q   <= '0;
         s_ch_q     <= '0;
         s_last_q   <= 1'b0;
         s_valid_q  <= 1'b0;
         cfg_done_q <= 1'b0;
         overrun_q  <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         act_q   <= 1'b1;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         if (cfg_done_q)
            tmr_q <= (tmr_q == TMR_END) ? '0 : tmr_q + 1'b1;
         if (cfg_end)
            cfg_done_q <= 1'b1;
         if (tick && state_q != IDLE)
            overrun_q <= 1'b1;
         if (to_hit)
            timeout_q <= 1'b1;
         if (cap) begin
            s_data_q  <= bus.db_in;
            s_ch_q    <= idx_q;
            s_last_q  <= (idx_q == LAST_CH);
            s_valid_q <= 1'b1;
         end else if (s_valid_q && bus.s_ready) begin
            s_valid_q <= 1'b0;
         end
      end
   end

   // act_q holds the FSM for the first cycle out of reset so pins stay idle
   // while rst is low, then config starts with its data setup cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      cap     = 1'b0;
      to_hit  = 1'b0;
      cfg_end = 1'b0;
      if (act_q) begin
         case (state_q)
            CFG_HI, CFG_LO: begin
               if (cnt_q == WR_END) begin
                  cnt_d = '0;
                  if (state_q == CFG_HI) begin
                     state_d = CFG_LO;
                  end else begin
                     state_d = IDLE;
                     cfg_end = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            IDLE: begin
               if (tick && bus.enable) begin
                  state_d = CONV;
                  cnt_d   = '0;
                  idx_d   = '0;
               end
            end
            CONV: begin
               if (cnt_q == CONV_END) begin
                  state_d = WAIT_BH;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            WAIT_BH: begin
               if (bus.busy) begin
                  state_d = WAIT_BL;
                  cnt_d   = '0;
               end else if (cnt_q == TO_END) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  to_hit  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            WAIT_BL: begin
               // after BUSY falls, wait here (not timing) until the output is free
               if (!bus.busy) begin
                  if (out_free) begin
                     state_d = RD_LO;
                     cnt_d   = '0;
                  end
               end else if (cnt_q == TO_END) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  to_hit  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            RD_LO: begin
               if (cnt_q == RD_LO_END) begin
                  cap     = 1'b1;
                  state_d = RD_HI;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            RD_HI: begin
               if (cnt_q < RD_HI_END) begin
                  cnt_d = cnt_q + 1'b1;
               end else if (idx_q == LAST_CH) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (out_free) begin
                  idx_d   = idx_q + 1'b1;
                  state_d = RD_LO;
                  cnt_d   = '0;
               end
            end
         endcase
      end
   end

   assign bus.cs_n        = !act_q || (state_q == IDLE);
   assign bus.wr_n        = !(in_cfg && cnt_q != '0 && cnt_q <= WR_LAST);
   assign bus.db_oe       = in_cfg;
   assign bus.db_out      = !in_cfg             ? 16'h0000 :
                            (state_q == CFG_HI) ? CFG_WORD[31:16] : CFG_WORD[15:0];
   assign bus.rd_n        = !(act_q && state_q == RD_LO);
   assign bus.convst      = (act_q && state_q == CONV) ? 4'hF : 4'h0;
   assign bus.hw_n        = 1'b1;
   assign bus.par_n       = 1'b0;
   assign bus.stby_n      = 1'b1;
   assign bus.s_data      = s_data_q;
   assign bus.s_ch        = s_ch_q;
   assign bus.s_last      = s_last_q;
   assign bus.s_valid     = s_valid_q;
   assign bus.cfg_done    = cfg_done_q;
   assign bus.overrun     = overrun_q;
   assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_ads8528_par_ctrl.sv
// Bench for ads8528_par_ctrl: ADC model feeds a scoreboard of expected samples,
// table-driven config/frame checks, plus stall, overrun and mid-frame reset cases.
module tb_ads8528_par_ctrl;
   localparam int SDIV = 1000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ads8528_par_ctrl_if bus0();
   ads8528_par_ctrl_if bus1();

   ads8528_par_ctrl #(.NUM_CH(8), .SAMPLE_DIV(SDIV)) dut (
      .clk(clk), .rst(rst), .bus(bus0.master)
   );
   ads8528_par_ctrl #(.NUM_CH(8), .SAMPLE_DIV(20)) dut_ovr (
      .clk(clk), .rst(rst), .bus(bus1.master)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   typedef struct packed {
      logic [15:0] data;
      logic [2:0]  ch;
      logic        last;
   } smp_t;
   smp_t sb[$];

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ADC model for the main DUT: BUSY pulse after CONVST, data = base + channel
   int          cur_busy = 10;
   logic [15:0] cur_base = 16'h1000;
   int          bcnt, mch, rd_pulses, acc_n;
   logic        conv_p, rd_p;
   smp_t        mon_e;

   always @(negedge clk) begin
      if (!rst) begin
         bcnt = 0; mch = 0; conv_p = 1'b0; rd_p = 1'b1;
         bus0.busy = 1'b0; bus0.db_in = 16'h0000;
         sb.delete();
      end else begin
         if (bus0.convst[0] && !conv_p) begin
            bcnt = (cur_busy > 0) ? cur_busy + 2 : 0;
            mch  = 0;
         end else if (bcnt != 0) begin
            bcnt--;
         end
         bus0.busy = (bcnt != 0) && (bcnt <= cur_busy);
         if (!bus0.rd_n && rd_p) begin
            bus0.db_in = cur_base + 16'(mch);
            sb.push_back('{data: cur_base + 16'(mch), ch: 3'(mch), last: (mch == 7)});
            rd_pulses++;
         end
         if (bus0.rd_n && !rd_p) mch++;
         conv_p = bus0.convst[0];
         rd_p   = bus0.rd_n;
      end
   end

   always @(negedge clk) begin
      if (rst && bus0.s_valid && bus0.s_ready) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 1);
         end else begin
            mon_e = sb.pop_front();
            chk("s_data", 32'(bus0.s_data), 32'(mon_e.data));
            chk("s_ch",   32'(bus0.s_ch),   32'(mon_e.ch));
            chk("s_last", 32'(bus0.s_last), 32'(mon_e.last));
            acc_n++;
         end
      end
   end

   // Overrun DUT: short tick period, channel sequence must never restart mid-frame
   int   b1, exp1, n1, seq1;
   logic c1p;
   assign bus1.db_in   = 16'h5000;
   assign bus1.s_ready = 1'b1;
   assign bus1.enable  = 1'b1;

   always @(negedge clk) begin
      if (!rst) begin
         b1 = 0; exp1 = 0; c1p = 1'b0; bus1.busy = 1'b0;
      end else begin
         if (bus1.convst[0] && !c1p) begin
            b1 = 12;
            if (exp1 != 0) seq1++;
         end else if (b1 != 0) begin
            b1--;
         end
         bus1.busy = (b1 != 0) && (b1 <= 10);
         c1p = bus1.convst[0];
         if (bus1.s_valid && bus1.s_ready) begin
            if (bus1.s_ch != 3'(exp1) || bus1.s_last != (exp1 == 7) || bus1.s_data != 16'h5000)
               seq1++;
            exp1 = (exp1 == 7) ? 0 : exp1 + 1;
            n1++;
         end
      end
   end

   typedef struct {
      logic        cs_n, wr_n, db_oe, cfg_done;
      logic [15:0] db_out;
   } cfgv_t;

   typedef struct {
      int          busy;
      logic [15:0] base;
      int          exp_n;
      logic        exp_to;
      logic        gap;
   } frm_t;

   task automatic chk_reset(input string tag);
      chk({tag, "_cs_n"},   32'(bus0.cs_n),        1);
      chk({tag, "_wr_n"},   32'(bus0.wr_n),        1);
      chk({tag, "_rd_n"},   32'(bus0.rd_n),        1);
      chk({tag, "_convst"}, 32'(bus0.convst),      0);
      chk({tag, "_db_oe"},  32'(bus0.db_oe),       0);
      chk({tag, "_valid"},  32'(bus0.s_valid),     0);
      chk({tag, "_data"},   32'(bus0.s_data),      0);
      chk({tag, "_ch"},     32'(bus0.s_ch),        0);
      chk({tag, "_last"},   32'(bus0.s_last),      0);
      chk({tag, "_cfgd"},   32'(bus0.cfg_done),    0);
      chk({tag, "_ovr"},    32'(bus0.overrun),     0);
      chk({tag, "_to"},     32'(bus0.timeout_err), 0);
      chk({tag, "_pins"},   32'({bus0.hw_n, bus0.par_n, bus0.stby_n}), 32'b101);
   endtask

   cfgv_t cfg_tab[9];
   frm_t  frm_tab[4];
   int    got, n, n0, r0, viol, last_start;

   initial begin
      cfg_tab[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h8000};
      cfg_tab[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h8000};
      cfg_tab[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h8000};
      cfg_tab[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h8000};
      cfg_tab[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h03FF};
      cfg_tab[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h03FF};
      cfg_tab[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h03FF};
      cfg_tab[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h03FF};
      cfg_tab[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000};
      frm_tab[0] = '{10, 16'h1000, 8, 1'b0, 1'b0};
      frm_tab[1] = '{10, 16'h1100, 8, 1'b0, 1'b1};
      frm_tab[2] = '{0,  16'h0000, 0, 1'b1, 1'b1};
      frm_tab[3] = '{6,  16'h1200, 8, 1'b1, 1'b1};

      bus0.enable  = 1'b1;
      bus0.s_ready = 1'b1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset("rst");
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         chk($sformatf("cfg%0d_cs_n", k),   32'(bus0.cs_n),     32'(cfg_tab[k].cs_n));
         chk($sformatf("cfg%0d_wr_n", k),   32'(bus0.wr_n),     32'(cfg_tab[k].wr_n));
         chk($sformatf("cfg%0d_db_oe", k),  32'(bus0.db_oe),    32'(cfg_tab[k].db_oe));
         chk($sformatf("cfg%0d_db_out", k), 32'(bus0.db_out),   32'(cfg_tab[k].db_out));
         chk($sformatf("cfg%0d_done", k),   32'(bus0.cfg_done), 32'(cfg_tab[k].cfg_done));
      end

      for (int i = 0; i < 4; i++) begin
         cur_busy = frm_tab[i].busy;
         cur_base = frm_tab[i].base;
         n0 = acc_n; r0 = rd_pulses;
         got = 0;
         for (int t = 0; t < 1500 && got == 0; t++) begin
            @(negedge clk);
            if (bus0.convst != 4'h0) got = 1;
         end
         chk($sformatf("f%0d_start", i), 32'(got), 1);
         chk($sformatf("f%0d_convst", i), 32'(bus0.convst), 32'hF);
         if (frm_tab[i].gap) chk($sformatf("f%0d_tick_gap", i), 32'(cyc - last_start), SDIV);
         last_start = cyc;
         n = 0; got = 0;
         for (int t = 0; t < 600 && got == 0; t++) begin
            @(negedge clk);
            n++;
            if (bus0.cs_n) got = 1;
         end
         chk($sformatf("f%0d_end", i), 32'(got), 1);
         if (frm_tab[i].busy == 0) chk("timeout_len", 32'(n), 257);
         repeat (3) @(negedge clk);
         chk($sformatf("f%0d_samples", i), 32'(acc_n - n0), 32'(frm_tab[i].exp_n));
         chk($sformatf("f%0d_rd_pulses", i), 32'(rd_pulses - r0), 32'(frm_tab[i].exp_n));
         chk($sformatf("f%0d_timeout", i), 32'(bus0.timeout_err), 32'(frm_tab[i].exp_to));
         chk($sformatf("f%0d_sb_left", i), 32'(sb.size()), 0);
      end
      chk("main_overrun", 32'(bus0.overrun), 0);

      // backpressure: stall with ch2 held in the output register
      cur_busy = 10; cur_base = 16'h1000; n0 = acc_n;
      got = 0;
      for (int t = 0; t < 1500 && got == 0; t++) begin
         @(negedge clk);
         if (bus0.s_valid && bus0.s_ch == 3'd1) got = 1;
      end
      chk("stall_ch1", 32'(got), 1);
      @(posedge clk); #1 bus0.s_ready = 1'b0;
      got = 0;
      for (int t = 0; t < 100 && got == 0; t++) begin
         @(negedge clk);
         if (bus0.s_valid && bus0.s_ch == 3'd2) got = 1;
      end
      chk("stall_ch2", 32'(got), 1);
      viol = 0;
      repeat (30) begin
         @(negedge clk);
         if (!bus0.rd_n || !bus0.s_valid || bus0.s_data !== 16'h1002) viol++;
      end
      chk("stall_hold", 32'(viol), 0);
      chk("stall_data", 32'(bus0.s_data), 32'h1002);
      @(posedge clk); #1 bus0.s_ready = 1'b1;
      got = 0;
      for (int t = 0; t < 200 && got == 0; t++) begin
         @(negedge clk);
         if (bus0.cs_n) got = 1;
      end
      repeat (3) @(negedge clk);
      chk("stall_end", 32'(got), 1);
      chk("stall_samples", 32'(acc_n - n0), 8);
      chk("stall_sb_left", 32'(sb.size()), 0);

      chk("ovr_flag", 32'(bus1.overrun), 1);
      chk("ovr_seq_err", 32'(seq1), 0);
      chk("ovr_progress", 32'(n1 >= 16), 1);
      chk("ovr_no_to", 32'(bus1.timeout_err), 0);

      // reset in the middle of the ch4 read strobe
      cur_busy = 10; cur_base = 16'h1300;
      got = 0;
      for (int t = 0; t < 1500 && got == 0; t++) begin
         @(negedge clk);
         if (!bus0.rd_n && mch == 4) got = 1;
      end
      chk("mid_rd_ch4", 32'(got), 1);
      rst = 1'b0;
      @(negedge clk);
      chk_reset("mid");
      @(posedge clk); #1 rst = 1'b1;
      got = 0;
      for (int t = 0; t < 20 && got == 0; t++) begin
         @(negedge clk);
         if (bus0.db_oe && bus0.db_out == 16'h8000 && !bus0.wr_n) got = 1;
      end
      chk("recfg_hi", 32'(got), 1);
      got = 0;
      for (int t = 0; t < 20 && got == 0; t++) begin
         @(negedge clk);
         if (bus0.db_oe && bus0.db_out == 16'h03FF && !bus0.wr_n) got = 1;
      end
      chk("recfg_lo", 32'(got), 1);
      got = 0;
      for (int t = 0; t < 20 && got == 0; t++) begin
         @(negedge clk);
         if (bus0.cfg_done) got = 1;
      end
      chk("recfg_done", 32'(got), 1);
      chk("recfg_oe_off", 32'(bus0.db_oe), 0);
      chk("recfg_cs_n", 32'(bus0.cs_n), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
